// File: rtl/gfx256_write_combiner.sv
// Pixel write combiner: merges same-line pixel writes into one 256-bit Wishbone-style line write.
// Optional idle flush of a partly filled line is enabled by defining GFX_WC_TIMEOUT_EN.
module gfx256_write_combiner #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pix_valid_i,
  output logic              pix_ready_o,
  input  logic [ADDR_W-1:0] pix_addr_i,
  input  logic [31:0]       pix_color_i,
  input  logic [1:0]        color_depth_i,
  input  logic              flush_i,
  output logic              idle_o,
  output logic              m_cyc_o,
  output logic              m_stb_o,
  output logic              m_we_o,
  output logic [ADDR_W-1:0] m_adr_o,
  output logic [31:0]       m_sel_o,
  output logic [255:0]      m_dat_o,
  input  logic              m_ack_i
);

  localparam int unsigned LINE_BYTES = 32;
  localparam int unsigned LINE_W     = 256;
  localparam int unsigned OFS_W      = 5;
  localparam int unsigned TAG_W      = ADDR_W - OFS_W;

  typedef enum logic [1:0] {ST_EMPTY, ST_FILL, ST_WRITE} state_e;

  state_e                state_q, state_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic [LINE_BYTES-1:0] sel_q, sel_d;
  logic [LINE_W-1:0]     dat_q, dat_d;

  logic [OFS_W-1:0]      pix_ofs;
  logic [TAG_W-1:0]      pix_tag;
  logic [3:0]            sel1;
  logic [31:0]           color_mask;
  logic [LINE_BYTES-1:0] pix_sel;
  logic [LINE_W-1:0]     pix_dat;
  logic [LINE_W-1:0]     pix_bmask;
  logic                  tag_hit;
  logic                  accept;
  logic                  to_fire;

  // Align one pixel into line position; lanes shifted past byte 31 fall off.
  always_comb begin
    pix_ofs = pix_addr_i[OFS_W-1:0];
    pix_tag = pix_addr_i[ADDR_W-1:OFS_W];
    unique case (color_depth_i)
      2'd0: sel1 = 4'h1;
      2'd1: sel1 = 4'h3;
      2'd2: sel1 = 4'h7;
      2'd3: sel1 = 4'hF;
    endcase
    color_mask = {{8{sel1[3]}}, {8{sel1[2]}}, {8{sel1[1]}}, {8{sel1[0]}}};
    pix_sel    = {28'd0, sel1} << pix_ofs;
    pix_dat    = LINE_W'(pix_color_i & color_mask) << {pix_ofs, 3'b000};
    for (int b = 0; b < LINE_BYTES; b++) begin
      pix_bmask[8*b +: 8] = {8{pix_sel[b]}};
    end
  end

  assign tag_hit = (pix_tag == tag_q);
  assign accept  = pix_valid_i && pix_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      tag_q   <= '0;
      sel_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          tag_d   = pix_tag;
          sel_d   = pix_sel;
          dat_d   = pix_dat;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (accept) begin
          sel_d = sel_q | pix_sel;
          dat_d = (dat_q & ~pix_bmask) | pix_dat;
        end
        // A same-tag pixel accepted alongside flush is merged before the write.
        if ((pix_valid_i && !tag_hit) || flush_i || to_fire) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (m_ack_i) begin
          sel_d   = '0;
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    pix_ready_o = 1'b0;
    idle_o      = 1'b0;
    m_cyc_o     = 1'b0;
    m_stb_o     = 1'b0;
    m_we_o      = 1'b0;
    m_adr_o     = '0;
    m_sel_o     = '0;
    m_dat_o     = '0;
    case (state_q)
      ST_EMPTY: begin
        pix_ready_o = 1'b1;
        idle_o      = 1'b1;
      end
      ST_FILL:  pix_ready_o = tag_hit;
      ST_WRITE: begin
        m_cyc_o = 1'b1;
        m_stb_o = 1'b1;
        m_we_o  = 1'b1;
        m_adr_o = {tag_q, OFS_W'(0)};
        m_sel_o = sel_q;
        m_dat_o = dat_q;
      end
      default: ;
    endcase
  end

`ifdef GFX_WC_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic [15:0] to_cnt_q, to_cnt_d;

  assign to_fire = (state_q == ST_FILL) && (to_cnt_q == TO_LAST) && !accept;

  // Counts idle FILL cycles; any accept or leaving FILL restarts it.
  always_comb begin
    to_cnt_d = '0;
    if ((state_q == ST_FILL) && (state_d == ST_FILL) && !accept) begin
      to_cnt_d = to_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) to_cnt_q <= '0;
    else       to_cnt_q <= to_cnt_d;
  end
`else
  logic unused_timeout;
  assign to_fire        = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

endmodule

// File: tb/tb_gfx256_write_combiner.sv
// Directed bench for gfx256_write_combiner: table of line writes plus hand-written bus corner cases.
module tb_gfx256_write_combiner;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned TO     = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              pix_valid;
  logic              pix_ready;
  logic [ADDR_W-1:0] pix_addr;
  logic [31:0]       pix_color;
  logic [1:0]        depth;
  logic              flush;
  logic              idle;
  logic              m_cyc, m_stb, m_we, m_ack;
  logic [ADDR_W-1:0] m_adr;
  logic [31:0]       m_sel;
  logic [255:0]      m_dat;

  int n_tests = 0;
  int n_fail  = 0;

  gfx256_write_combiner #(.ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .pix_valid_i(pix_valid), .pix_ready_o(pix_ready),
    .pix_addr_i(pix_addr), .pix_color_i(pix_color), .color_depth_i(depth),
    .flush_i(flush), .idle_o(idle),
    .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_we_o(m_we),
    .m_adr_o(m_adr), .m_sel_o(m_sel), .m_dat_o(m_dat), .m_ack_i(m_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  addr;
    logic [31:0]  color;
    logic [1:0]   depth;
    bit           last;
    logic [31:0]  exp_adr;
    logic [31:0]  exp_sel;
    logic [255:0] exp_dat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [31:0] a, logic [31:0] c, logic [1:0] d, bit l,
                              logic [31:0] ea, logic [31:0] es, logic [255:0] ed);
    vec_t v;
    v.addr = a; v.color = c; v.depth = d; v.last = l;
    v.exp_adr = ea; v.exp_sel = es; v.exp_dat = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present a pixel (optionally with flush) until accepted, bounded.
  task automatic send_pix(input logic [31:0] a, input logic [31:0] c, input logic [1:0] d,
                          input bit fl);
    bit got;
    got = 1'b0;
    pix_valid = 1'b1; pix_addr = a; pix_color = c; depth = d; flush = fl;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (pix_ready) got = 1'b1;
      @(posedge clk); #1;
    end
    pix_valid = 1'b0; flush = 1'b0;
    if (!got) chk("pixel accept timeout", 256'(got), 256'd1);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  // Wait for a bus write, check it, acknowledge it and check return to idle.
  task automatic expect_write(input string name, input logic [31:0] ea, input logic [31:0] es,
                              input logic [255:0] ed);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (m_cyc) got = 1'b1;
    end
    chk({name, " cyc"}, 256'(got), 256'd1);
    chk({name, " stb/we"}, 256'({m_stb, m_we}), 256'd3);
    chk({name, " ready"}, 256'(pix_ready), 256'd0);
    chk({name, " adr"}, 256'(m_adr), 256'(ea));
    chk({name, " sel"}, 256'(m_sel), 256'(es));
    chk({name, " dat"}, m_dat, ed);
    @(posedge clk); #1;
    m_ack = 1'b1;
    @(posedge clk); #1;
    m_ack = 1'b0;
    @(negedge clk);
    chk({name, " idle after ack"}, 256'({idle, m_cyc}), 256'd2);
  endtask

  initial begin
    bit   got;
    int   first;
    int   cyc_cnt;
    rst = 1'b1; pix_valid = 1'b0; pix_addr = '0; pix_color = '0; depth = '0;
    flush = 1'b0; m_ack = 1'b0;

    // Line writes: pixels of one line, last entry carries the expected bus write.
    vecs.push_back(mk(32'h100, 32'h11, 2'd0, 0, 0, 0, 0));
    vecs.push_back(mk(32'h101, 32'h22, 2'd0, 0, 0, 0, 0));
    vecs.push_back(mk(32'h102, 32'h33, 2'd0, 0, 0, 0, 0));
    vecs.push_back(mk(32'h103, 32'h44, 2'd0, 1, 32'h100, 32'h0000000F, 256'h44332211));
    vecs.push_back(mk(32'h300, 32'h55, 2'd0, 0, 0, 0, 0));
    vecs.push_back(mk(32'h300, 32'h66, 2'd0, 1, 32'h300, 32'h00000001, 256'h66));
    vecs.push_back(mk(32'h31E, 32'h00ABCDEF, 2'd2, 1, 32'h300, 32'hC0000000,
                      256'hCDEF << 240));
    vecs.push_back(mk(32'h01F, 32'h12345678, 2'd1, 1, 32'h000, 32'h80000000,
                      256'h78 << 248));
    vecs.push_back(mk(32'h41C, 32'hDEADBEEF, 2'd3, 1, 32'h400, 32'hF0000000,
                      256'hDEADBEEF << 224));
    vecs.push_back(mk(32'h500, 32'h11223344, 2'd3, 0, 0, 0, 0));
    vecs.push_back(mk(32'h502, 32'hAA, 2'd0, 1, 32'h500, 32'h0000000F, 256'h11AA3344));
    vecs.push_back(mk(32'h605, 32'hFFFFFF5A, 2'd0, 1, 32'h600, 32'h00000020,
                      256'h5A << 40));

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset ready/idle", 256'({pix_ready, idle}), 256'd3);
    chk("reset cyc/stb/we", 256'({m_cyc, m_stb, m_we}), 256'd0);
    chk("reset adr/sel", 256'({m_adr, m_sel}), 256'd0);
    chk("reset dat", m_dat, 256'd0);

    // Flush and stray ack while empty do nothing.
    @(posedge clk); #1;
    flush = 1'b1; m_ack = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; m_ack = 1'b0;
    @(negedge clk);
    chk("flush/ack in EMPTY", 256'({idle, m_cyc}), 256'd2);

    foreach (vecs[i]) begin
      send_pix(vecs[i].addr, vecs[i].color, vecs[i].depth, 1'b0);
      if (vecs[i].last) begin
        pulse_flush();
        expect_write($sformatf("vec%0d", i), vecs[i].exp_adr, vecs[i].exp_sel, vecs[i].exp_dat);
      end
    end

    // Tag miss stalls the new pixel until the old line is written.
    send_pix(32'h204, 32'hAABBCCDD, 2'd3, 1'b0);
    pix_valid = 1'b1; pix_addr = 32'h240; pix_color = 32'h1234; depth = 2'd1;
    @(negedge clk);
    chk("miss ready low", 256'(pix_ready), 256'd0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (m_cyc) got = 1'b1;
    end
    chk("miss write cyc", 256'(got), 256'd1);
    chk("miss write adr", 256'(m_adr), 256'h200);
    chk("miss write sel", 256'(m_sel), 256'h000000F0);
    chk("miss write dat", m_dat, 256'hAABBCCDD << 32);
    chk("miss write ready", 256'(pix_ready), 256'd0);
    @(posedge clk); #1;
    m_ack = 1'b1;
    @(posedge clk); #1;
    m_ack = 1'b0;
    @(negedge clk);
    chk("held pixel ready after ack", 256'({pix_ready, idle}), 256'd3);
    @(posedge clk); #1;
    pix_valid = 1'b0;
    @(negedge clk);
    chk("held pixel accepted", 256'(idle), 256'd0);
    pulse_flush();
    expect_write("second line", 32'h240, 32'h3, 256'h1234);

    // Same-tag pixel accepted in the flush cycle is included.
    send_pix(32'h700, 32'h01, 2'd0, 1'b0);
    send_pix(32'h701, 32'h02, 2'd0, 1'b1);
    expect_write("flush+pixel", 32'h700, 32'h3, 256'h0201);

    // Write held without ack, then asynchronous reset mid-write.
    send_pix(32'h808, 32'h01020304, 2'd3, 1'b0);
    pulse_flush();
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (m_cyc) got = 1'b1;
    end
    chk("hold cyc seen", 256'(got), 256'd1);
    cyc_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_cyc && m_stb && !pix_ready && m_adr == 32'h800 && m_sel == 32'h00000F00 &&
          m_dat == (256'h01020304 << 64))
        cyc_cnt++;
    end
    chk("write held stable 10 cycles", 256'(cyc_cnt), 256'd10);
    #2 rst = 1'b1;
    #1;
    chk("async reset cyc/stb", 256'({m_cyc, m_stb}), 256'd0);
    chk("async reset idle/sel", 256'({idle, m_sel}), 256'h1_00000000);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("after reset idle", 256'({idle, m_cyc}), 256'd2);

    // Single pixel followed by silence.
    send_pix(32'h904, 32'h77, 2'd0, 1'b0);
`ifdef GFX_WC_TIMEOUT_EN
    first = 0;
    for (int k = 1; k <= 10 && first == 0; k++) begin
      @(negedge clk);
      if (m_cyc) first = k;
    end
    chk("timeout write cycle", 256'(first), 256'(TO + 1));
    expect_write("timeout line", 32'h900, 32'h10, 256'h77 << 32);
`else
    first = 0;
    cyc_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (m_cyc) cyc_cnt++;
    end
    chk("no auto flush", 256'(cyc_cnt), 256'(first));
    @(posedge clk); #1;
    pulse_flush();
    expect_write("late flush", 32'h900, 32'h10, 256'h77 << 32);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
